// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by the transmitter, receiver and the transmit
// scheduler: default frame geometry, the frame-length helper and the
// scheduler state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package uart_pkg;

  // Default frame geometry; the transmitter and receiver use the same values
  localparam int DATA_BITS_DEF = 8;
  localparam int OS_TICKS_DEF  = 16;
  localparam int SB_TICK_DEF   = 16;

  // Number of sTick events from the start of the start bit to the end of the
  // stop bit: start bit + data bits at osTicks each, plus the stop bit.
  function automatic int frameTicks(input int osTicks, input int dataBits,
                                    input int sbTick);
    return osTicks * (1 + dataBits) + sbTick;
  endfunction

  // Scheduler state encoding
  typedef enum logic [1:0] {
    SCHED_IDLE   = 2'd0,
    SCHED_LAUNCH = 2'd1,
    SCHED_FRAME  = 2'd2,
    SCHED_GAP    = 2'd3
  } schedState_t;

endpackage

// File: rtl/uart_rr_pick.sv
// ---------------------------------------------------------------------------
// uart_rr_pick
// Purely combinational round-robin picker. The search starts one past the
// previous winner and wraps around, so the previous winner has the lowest
// priority.
// Ports:
//   reqValid  in  NUM_REQ  request bits
//   lastGrant in  ID_W     index of the previous winner
//   anyValid  out 1        at least one request is set
//   winner    out ID_W     index of the chosen requester (0 when none)
// ---------------------------------------------------------------------------
module uart_rr_pick #(
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] reqValid,
  input  logic [ID_W-1:0]    lastGrant,
  output logic               anyValid,
  output logic [ID_W-1:0]    winner
);

  logic [ID_W-1:0] idx;

  // Walk the requesters starting at lastGrant+1 (modulo NUM_REQ); the first
  // valid one found wins and later candidates are ignored.
  always_comb begin
    anyValid = 1'b0;
    winner   = '0;
    idx      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(lastGrant) + k) % NUM_REQ);
      if (!anyValid && reqValid[idx]) begin
        anyValid = 1'b1;
        winner   = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// ---------------------------------------------------------------------------
// uart_tx_sched
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte
// sources. Grants a requester in IDLE, pulses txStart for one cycle, holds
// txDin for the whole frame and counts sTick to find the end of the frame,
// since the transmitter gives no end-of-frame indication.
// Ports:
//   clk       in  1                  system clock
//   reset     in  1                  asynchronous reset, active low
//   sTick     in  1                  baud oversample tick, one clk wide
//   reqValid  in  NUM_REQ            request valid per requester
//   reqData   in  NUM_REQ*DATA_BITS  requester i byte at [i*DATA_BITS +: DATA_BITS]
//   reqReady  out NUM_REQ            one-hot, one-cycle accept pulse
//   txStart   out 1                  transmitter start request
//   txDin     out DATA_BITS          byte to the transmitter
//   grantId   out $clog2(NUM_REQ)    index of the current or last winner
//   busy      out 1                  a frame is in flight
// ---------------------------------------------------------------------------
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int OS_TICKS  = OS_TICKS_DEF,
  parameter int SB_TICK   = SB_TICK_DEF,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sTick,
  input  logic [NUM_REQ-1:0]            reqValid,
  input  logic [NUM_REQ*DATA_BITS-1:0]  reqData,
  output logic [NUM_REQ-1:0]            reqReady,
  output logic                          txStart,
  output logic [DATA_BITS-1:0]          txDin,
  output logic [ID_W-1:0]               grantId,
  output logic                          busy
);

  localparam int FRAME_TICKS = frameTicks(OS_TICKS, DATA_BITS, SB_TICK);
  localparam int CNT_W       = $clog2(FRAME_TICKS);

  localparam logic [1:0] ST_IDLE   = SCHED_IDLE;
  localparam logic [1:0] ST_LAUNCH = SCHED_LAUNCH;
  localparam logic [1:0] ST_FRAME  = SCHED_FRAME;
  localparam logic [1:0] ST_GAP    = SCHED_GAP;

  logic [1:0]           state;
  logic [CNT_W-1:0]     tickCnt;
  logic [ID_W-1:0]      lastGrant;
  logic                 anyValid;
  logic [ID_W-1:0]      winner;
  logic                 grantNow;
  logic [DATA_BITS-1:0] winnerByte;

  uart_rr_pick #(.NUM_REQ(NUM_REQ)) rrPick (
    .reqValid  (reqValid),
    .lastGrant (lastGrant),
    .anyValid  (anyValid),
    .winner    (winner)
  );

  // The handshake completes in the IDLE cycle itself, so reqReady is
  // combinational; the requester moves on at the following edge.
  assign grantNow = (state == ST_IDLE) && anyValid;
  assign reqReady = grantNow ? (NUM_REQ'(1) << winner) : '0;
  assign txStart  = (state == ST_LAUNCH);
  assign busy     = (state != ST_IDLE);

  // Byte of the current winner, selected with constant part-selects.
  always_comb begin
    winnerByte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        winnerByte = reqData[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  // Scheduler FSM. txDin is only loaded on a grant, which keeps it stable
  // through the transmitter's start bit and the rest of the frame. The tick
  // counter is cleared in LAUNCH, so an sTick seen in that cycle is not
  // counted; the move to GAP happens on the last tick, so the counter never
  // wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      tickCnt   <= '0;
      lastGrant <= ID_W'(NUM_REQ - 1);
      txDin     <= '0;
      grantId   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (anyValid) begin
            txDin     <= winnerByte;
            grantId   <= winner;
            lastGrant <= winner;
            state     <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          tickCnt <= '0;
          state   <= ST_FRAME;
        end
        ST_FRAME: begin
          if (sTick) begin
            if (tickCnt == CNT_W'(FRAME_TICKS - 1)) begin
              state <= ST_GAP;
            end else begin
              tickCnt <= tickCnt + CNT_W'(1);
            end
          end
        end
        ST_GAP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
